// File: rtl/xio_rx.sv
// Receive side of the xio parallel link: synchronises the sender's RTS/strobe,
// rebuilds each frame into a command plus 32-bit word, and flags malformed frames.
module xio_rx #(
   parameter logic [3:0] CMD_PAYLOAD = 4'h1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  rData,
   input  logic        rRts,
   input  logic        rClk,
   output logic        rCts,
   output logic [3:0]  cmdOut,
   output logic [31:0] dataOut,
   output logic        outValid,
   input  logic        outReady,
   output logic        errValid,
   output logic [1:0]  errCode
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CMD   = 3'd1,
      ST_DATA  = 3'd2,
      ST_END   = 3'd3,
      ST_DRAIN = 3'd4
   } state_t;

   localparam logic [1:0] ERR_BADCMD = 2'd1;
   localparam logic [1:0] ERR_SHORT  = 2'd2;
   localparam logic [1:0] ERR_LONG   = 2'd3;

   logic       rts_s1_q, rts_s2_q;
   logic       clk_s1_q, clk_s2_q, clk_s3_q;
   logic [7:0] data_p1_q, data_p2_q;

   state_t      state_q, state_d;
   logic [3:0]  cmd_q, cmd_d;
   logic [31:0] data_q, data_d;
   logic [2:0]  count_q, count_d;
   logic        rcts_q, rcts_d;
   logic [3:0]  cmd_out_q, cmd_out_d;
   logic [31:0] data_out_q, data_out_d;
   logic        out_valid_q, out_valid_d;
   logic        err_valid_q, err_valid_d;
   logic [1:0]  err_code_q, err_code_d;

   logic       rts_s;
   logic       clk_rise_s;
   logic [7:0] byte_s;

   assign rts_s      = rts_s2_q;
   assign clk_rise_s = clk_s2_q & ~clk_s3_q;
   assign byte_s     = data_p2_q;

   // Synchronisers for the asynchronous link inputs; data pipeline tracks the strobe path.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rts_s1_q  <= 1'b0;
         rts_s2_q  <= 1'b0;
         clk_s1_q  <= 1'b0;
         clk_s2_q  <= 1'b0;
         clk_s3_q  <= 1'b0;
         data_p1_q <= 8'h00;
         data_p2_q <= 8'h00;
      end else begin
         rts_s1_q  <= rRts;
         rts_s2_q  <= rts_s1_q;
         clk_s1_q  <= rClk;
         clk_s2_q  <= clk_s1_q;
         clk_s3_q  <= clk_s2_q;
         data_p1_q <= rData;
         data_p2_q <= data_p1_q;
      end
   end

   // Frame state, assembly registers and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cmd_q       <= 4'h0;
         data_q      <= 32'h0000_0000;
         count_q     <= 3'd0;
         rcts_q      <= 1'b0;
         cmd_out_q   <= 4'h0;
         data_out_q  <= 32'h0000_0000;
         out_valid_q <= 1'b0;
         err_valid_q <= 1'b0;
         err_code_q  <= 2'd0;
      end else begin
         state_q     <= state_d;
         cmd_q       <= cmd_d;
         data_q      <= data_d;
         count_q     <= count_d;
         rcts_q      <= rcts_d;
         cmd_out_q   <= cmd_out_d;
         data_out_q  <= data_out_d;
         out_valid_q <= out_valid_d;
         err_valid_q <= err_valid_d;
         err_code_q  <= err_code_d;
      end
   end

   // Next-state logic: a byte arriving in the same cycle as RTS falling is handled first.
   always_comb begin
      state_d     = state_q;
      cmd_d       = cmd_q;
      data_d      = data_q;
      count_d     = count_q;
      cmd_out_d   = cmd_out_q;
      data_out_d  = data_out_q;
      out_valid_d = out_valid_q & ~outReady;
      err_valid_d = 1'b0;
      err_code_d  = 2'd0;
      rcts_d      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (rts_s && rcts_q) begin
               state_d = ST_CMD;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CMD: begin
            if (clk_rise_s) begin
               if (byte_s[7:4] != 4'h0) begin
                  err_valid_d = 1'b1;
                  err_code_d  = ERR_BADCMD;
                  state_d     = ST_DRAIN;
               end else begin
                  cmd_d   = byte_s[3:0];
                  data_d  = 32'h0000_0000;
                  count_d = 3'd0;
                  state_d = (byte_s[3:0] == CMD_PAYLOAD) ? ST_DATA : ST_END;
               end
            end else if (!rts_s) begin
               err_valid_d = 1'b1;
               err_code_d  = ERR_SHORT;
               state_d     = ST_IDLE;
            end else begin
               state_d = ST_CMD;
            end
         end
         ST_DATA: begin
            if (clk_rise_s) begin
               data_d  = {data_q[23:0], byte_s};
               count_d = count_q + 3'd1;
               state_d = (count_q == 3'd3) ? ST_END : ST_DATA;
            end else if (!rts_s) begin
               err_valid_d = 1'b1;
               err_code_d  = ERR_SHORT;
               state_d     = ST_IDLE;
            end else begin
               state_d = ST_DATA;
            end
         end
         ST_END: begin
            if (clk_rise_s) begin
               err_valid_d = 1'b1;
               err_code_d  = ERR_LONG;
               state_d     = ST_DRAIN;
            end else if (!rts_s) begin
               cmd_out_d   = cmd_q;
               data_out_d  = data_q;
               out_valid_d = 1'b1;
               state_d     = ST_IDLE;
            end else begin
               state_d = ST_END;
            end
         end
         ST_DRAIN: begin
            if (!rts_s) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DRAIN;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // CTS in idle stays low through the handshake cycle so a new RTS waits one clock.
      case (state_d)
         ST_IDLE:          rcts_d = ~out_valid_q & ~out_valid_d;
         ST_CMD, ST_DATA:  rcts_d = 1'b1;
         default:          rcts_d = 1'b0;
      endcase
   end

   assign rCts     = rcts_q;
   assign cmdOut   = cmd_out_q;
   assign dataOut  = data_out_q;
   assign outValid = out_valid_q;
   assign errValid = err_valid_q;
   assign errCode  = err_code_q;

endmodule
